fm_seq_ctrl: RTL and testbench

FM_SEQ_CTRL -- requirements
Module: fm_seq_ctrl

---
 rtl/fm_seq_ctrl.sv | 174 +++++++++++++++++
 tb/tb_fm_seq_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/fm_seq_ctrl.sv
// fm_seq_ctrl
// Sequencing controller for a double-banked fragment memory (FM). The write
// side streams base words into the FM fill bank while a mirror counter tracks
// the FM write address; once the fill bank is full and the read side has been
// released, the banks are swapped. The read side serves fragment requests
// against the loaded bank through a one-deep, back-pressured output register.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   s_valid/s_data/s_ready   input word stream (accepted while filling)
//   req_valid/req_idx/
//   req_last/req_ready       fragment requests; req_last releases the bank
//   frag_valid/frag_data/
//   frag_ready               fragment output, one-cycle latency
//   fm_rst_n, fm_wdata,
//   fm_chg_idx, fm_frag_idx  FM control outputs
//   fm_rdata, fm_wait        FM read data (combinational) and wait status
//   underrun, range_err,
//   sync_err                 sticky status flags
//   bank_cnt                 completed swaps, wrapping
//
// Write-side states (derived from the mirror counter, no separate register)
//   state | meaning
//   FILL  | wcnt < last: a word is written every cycle (zero if none offered)
//   SWAP  | wcnt == last and read side free: last word written, banks swap
//   HOLD  | wcnt == last and read side busy: no write, FM waits
module fm_seq_ctrl #(
  parameter int FM_BUFFER_SIZE    = 32,
  parameter int DATA_BITS         = 2,
  parameter int INDICE_LEN        = 6,
  parameter int SIGNED_INDICE_LEN = 7,
  parameter int FRAG_LEN          = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         s_valid,
  input  logic [DATA_BITS-1:0]         s_data,
  output logic                         s_ready,
  input  logic                         req_valid,
  input  logic [SIGNED_INDICE_LEN-1:0] req_idx,
  input  logic                         req_last,
  output logic                         req_ready,
  output logic                         frag_valid,
  output logic [FRAG_LEN-1:0]          frag_data,
  input  logic                         frag_ready,
  output logic                         fm_rst_n,
  output logic [DATA_BITS-1:0]         fm_wdata,
  output logic                         fm_chg_idx,
  output logic [SIGNED_INDICE_LEN-1:0] fm_frag_idx,
  input  logic [FRAG_LEN-1:0]          fm_rdata,
  input  logic                         fm_wait,
  output logic                         underrun,
  output logic                         range_err,
  output logic                         sync_err,
  output logic [7:0]                   bank_cnt
);

  localparam int WCNT_W     = $clog2(FM_BUFFER_SIZE);
  localparam int FRAG_WORDS = FRAG_LEN / DATA_BITS;
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(FM_BUFFER_SIZE - 1);
  localparam logic [INDICE_LEN-1:0] IDX_MAX = INDICE_LEN'(FM_BUFFER_SIZE - 1);
  localparam logic signed [SIGNED_INDICE_LEN-1:0] IDX_MIN =
    SIGNED_INDICE_LEN'(-FRAG_WORDS);

  logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
  logic                rd_loaded_q, rd_loaded_d;
  logic                frag_valid_q, frag_valid_d;
  logic [FRAG_LEN-1:0] frag_data_q, frag_data_d;
  logic                underrun_q, underrun_d;
  logic                range_err_q, range_err_d;
  logic                sync_err_q, sync_err_d;
  logic [7:0]          bank_cnt_q, bank_cnt_d;

  logic full;
  logic rd_ready;
  logic req_acc;
  logic swap;
  logic wr_en;
  logic idx_neg;
  logic idx_oor;

  always_comb begin
    full     = (wcnt_q == WCNT_LAST);
    rd_ready = ~rst & rd_loaded_q & (~frag_valid_q | frag_ready);
    req_acc  = req_valid & rd_ready;
    // A req_last accepted in the same cycle frees the read side immediately,
    // so the swap does not have to wait a cycle in HOLD.
    swap     = ~rst & full & (~rd_loaded_q | (req_acc & req_last));
    wr_en    = ~rst & (~full | swap);
    // Non-negative indices fit in the low INDICE_LEN bits.
    idx_neg  = req_idx[SIGNED_INDICE_LEN-1];
    idx_oor  = idx_neg ? ($signed(req_idx) < IDX_MIN)
                       : (req_idx[INDICE_LEN-1:0] > IDX_MAX);
  end

  always_comb begin
    wcnt_d       = wcnt_q;
    rd_loaded_d  = rd_loaded_q;
    frag_valid_d = frag_valid_q;
    frag_data_d  = frag_data_q;
    underrun_d   = underrun_q;
    range_err_d  = range_err_q;
    sync_err_d   = sync_err_q;
    bank_cnt_d   = bank_cnt_q;

    if (!full) begin
      wcnt_d = wcnt_q + 1'b1;
    end else if (swap) begin
      wcnt_d = '0;
    end

    if (wr_en && !s_valid) begin
      underrun_d = 1'b1;
    end

    if (swap) begin
      rd_loaded_d = 1'b1;
      bank_cnt_d  = bank_cnt_q + 8'd1;
    end else if (req_acc && req_last) begin
      rd_loaded_d = 1'b0;
    end

    // fm_rdata still reflects the old read bank on the swap edge.
    if (req_acc) begin
      frag_valid_d = 1'b1;
      frag_data_d  = idx_oor ? '0 : fm_rdata;
      if (idx_oor) begin
        range_err_d = 1'b1;
      end
    end else if (frag_ready) begin
      frag_valid_d = 1'b0;
    end

    if (fm_wait != (full & ~swap)) begin
      sync_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt_q       <= '0;
      rd_loaded_q  <= 1'b0;
      frag_valid_q <= 1'b0;
      frag_data_q  <= '0;
      underrun_q   <= 1'b0;
      range_err_q  <= 1'b0;
      sync_err_q   <= 1'b0;
      bank_cnt_q   <= '0;
    end else begin
      wcnt_q       <= wcnt_d;
      rd_loaded_q  <= rd_loaded_d;
      frag_valid_q <= frag_valid_d;
      frag_data_q  <= frag_data_d;
      underrun_q   <= underrun_d;
      range_err_q  <= range_err_d;
      sync_err_q   <= sync_err_d;
      bank_cnt_q   <= bank_cnt_d;
    end
  end

  assign s_ready     = wr_en;
  assign req_ready   = rd_ready;
  assign fm_chg_idx  = swap;
  assign fm_rst_n    = ~rst;
  assign fm_wdata    = (wr_en & s_valid) ? s_data : '0;
  assign fm_frag_idx = (~rst & req_valid) ? req_idx : '0;
  assign frag_valid  = frag_valid_q;
  assign frag_data   = frag_data_q;
  assign underrun    = underrun_q;
  assign range_err   = range_err_q;
  assign sync_err    = sync_err_q;
  assign bank_cnt    = bank_cnt_q;

endmodule

// File: tb/tb_fm_seq_ctrl.sv
module tb_fm_seq_ctrl;

  localparam int N = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_valid = 1'b0;
  logic [1:0]  s_data = '0;
  logic        s_ready;
  logic        req_valid = 1'b0;
  logic [6:0]  req_idx = '0;
  logic        req_last = 1'b0;
  logic        req_ready;
  logic        frag_valid;
  logic [15:0] frag_data;
  logic        frag_ready = 1'b0;
  logic        fm_rst_n;
  logic [1:0]  fm_wdata;
  logic        fm_chg_idx;
  logic [6:0]  fm_frag_idx;
  logic [15:0] fm_rdata;
  logic        fm_wait;
  logic        underrun;
  logic        range_err;
  logic        sync_err;
  logic [7:0]  bank_cnt;
  logic        wait_flip = 1'b0;

  fm_seq_ctrl dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .req_valid(req_valid), .req_idx(req_idx), .req_last(req_last), .req_ready(req_ready),
    .frag_valid(frag_valid), .frag_data(frag_data), .frag_ready(frag_ready),
    .fm_rst_n(fm_rst_n), .fm_wdata(fm_wdata), .fm_chg_idx(fm_chg_idx),
    .fm_frag_idx(fm_frag_idx), .fm_rdata(fm_rdata), .fm_wait(fm_wait),
    .underrun(underrun), .range_err(range_err), .sync_err(sync_err),
    .bank_cnt(bank_cnt)
  );

  always #5 clk = ~clk;

  // ---------------- FM behavioural model (driven by DUT outputs) ----------
  logic [1:0] fm_mem [0:1][0:N-1];
  logic [4:0] fa = '0;
  logic       fb = 1'b0;
  logic       fm_true_wait;

  assign fm_true_wait = fm_rst_n && (fa == 5'd31) && !fm_chg_idx;
  assign fm_wait      = fm_true_wait ^ wait_flip;

  always @(posedge clk) begin
    if (!fm_rst_n) begin
      fa <= '0;
      fb <= 1'b0;
    end else if (!fm_true_wait) begin
      fm_mem[fb][fa] <= fm_wdata;
      if (fa == 5'd31) begin
        fa <= '0;
        fb <= ~fb;
      end else begin
        fa <= fa + 5'd1;
      end
    end
  end

  always_comb begin
    fm_rdata = '0;
    for (int k = 0; k < 8; k++) begin
      int a;
      a = $signed(fm_frag_idx) + k;
      if (a >= 0 && a < N) fm_rdata[2*k +: 2] = fm_mem[~fb][a[4:0]];
    end
  end

  // ---------------- scoreboard and reference model ------------------------
  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];

  logic [1:0] m_fill[$];
  logic [1:0] m_rbank [0:N-1];
  bit m_loaded = 0, m_fv = 0, m_under = 0, m_range = 0, m_sync = 0, m_prev_rst = 0;
  int m_bank_cnt = 0;

  function automatic void chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic logic [15:0] ref_frag(input int idx);
    logic [15:0] f;
    f = '0;
    if (idx > N - 1 || idx < -8) return f;
    for (int k = 0; k < 8; k++)
      if (idx + k >= 0 && idx + k < N) f[2*k +: 2] = m_rbank[idx + k];
    return f;
  endfunction

  task automatic cycle(input bit r, input bit sv, input bit [1:0] sd, input bit rv,
                       input int ridx, input bit rl, input bit fr, input bit wf);
    bit full, exp_rr, acc, exp_chg, exp_sr;
    @(negedge clk);
    rst = r; s_valid = sv; s_data = sd; req_valid = rv; req_idx = 7'(ridx);
    req_last = rl; frag_ready = fr; wait_flip = wf;
    #1;
    full    = (m_fill.size() == N - 1);
    exp_rr  = !r && m_loaded && (!m_fv || fr);
    acc     = rv && exp_rr;
    exp_chg = !r && full && (!m_loaded || (acc && rl));
    exp_sr  = !r && (!full || exp_chg);

    chk("s_ready", s_ready, exp_sr);
    chk("req_ready", req_ready, exp_rr);
    chk("fm_chg_idx", fm_chg_idx, exp_chg);
    chk("fm_rst_n", fm_rst_n, !r);
    chk("fm_frag_idx", fm_frag_idx, (rv && !r) ? (ridx & 127) : 0);
    if (exp_sr || r) chk("fm_wdata", fm_wdata, (exp_sr && sv) ? sd : 0);
    if (!r || m_prev_rst) begin
      chk("frag_valid", frag_valid, m_fv);
      chk("underrun", underrun, m_under);
      chk("range_err", range_err, m_range);
      chk("sync_err", sync_err, m_sync);
      chk("bank_cnt", bank_cnt, m_bank_cnt);
    end
    if (m_prev_rst) chk("frag_data_rst", frag_data, 0);

    if (r) begin
      m_fill.delete();
      m_loaded = 0; m_fv = 0; m_under = 0; m_range = 0; m_sync = 0;
      m_bank_cnt = 0;
      exp_q.delete();
    end else begin
      if (acc) begin
        exp_q.push_back(ref_frag(ridx));
        if (ridx > N - 1 || ridx < -8) m_range = 1;
      end
      if (exp_sr) begin
        m_fill.push_back(sv ? sd : 2'b00);
        if (!sv) m_under = 1;
      end
      if (exp_chg) begin
        for (int i = 0; i < N; i++) m_rbank[i] = m_fill[i];
        m_fill.delete();
        m_bank_cnt = (m_bank_cnt + 1) & 255;
        m_loaded = 1;
      end else if (acc && rl) begin
        m_loaded = 0;
      end
      if (acc) m_fv = 1;
      else if (fr) m_fv = 0;
      if (wf) m_sync = 1;
    end
    m_prev_rst = r;
  endtask

  // Monitor: compares every presented fragment with the queue head and pops
  // it on the handshake.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!rst && frag_valid) begin
        chk("frag_pending", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          chk("frag_data", frag_data, exp_q[0]);
          if (frag_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) cycle(1, 0, 0, 0, 0, 0, 0, 0);
    // first bank: read side free, swap at the 32nd word
    repeat (32) cycle(0, 1, 2'($urandom_range(0, 3)), 0, 0, 0, 1, 0);
    // second bank fills then holds with no requests
    repeat (42) cycle(0, 1, 2'($urandom_range(0, 3)), 0, 0, 0, 1, 0);
    // req_last from HOLD: swap in the same cycle, fragment from the old bank
    cycle(0, 1, 2'($urandom_range(0, 3)), 1, 4, 1, 1, 0);
    cycle(0, 1, 2'($urandom_range(0, 3)), 1, -3, 0, 1, 0);
    // back-pressure for 5 cycles, then release with a waiting request
    cycle(0, 1, 2'($urandom_range(0, 3)), 1, 10, 0, 0, 0);
    repeat (5) cycle(0, 1, 2'($urandom_range(0, 3)), 1, 12, 0, 0, 0);
    cycle(0, 1, 2'($urandom_range(0, 3)), 1, 12, 0, 1, 0);
    // two-word underrun mid-fill
    cycle(0, 0, 0, 0, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 0, 0, 1, 0);
    // index boundaries
    cycle(0, 1, 2'($urandom_range(0, 3)), 1, 31, 0, 1, 0);
    cycle(0, 1, 2'($urandom_range(0, 3)), 1, -8, 0, 1, 0);
    cycle(0, 1, 2'($urandom_range(0, 3)), 1, 0, 0, 1, 0);
    cycle(0, 1, 2'($urandom_range(0, 3)), 1, 40, 0, 1, 0);
    cycle(0, 1, 2'($urandom_range(0, 3)), 1, -9, 0, 1, 0);
    cycle(0, 1, 2'($urandom_range(0, 3)), 1, 63, 0, 1, 0);
    cycle(0, 1, 2'($urandom_range(0, 3)), 1, -64, 1, 1, 0);
    // FM/mirror disagreement
    cycle(0, 1, 2'($urandom_range(0, 3)), 0, 0, 0, 1, 1);
    repeat (2) cycle(1, 0, 0, 0, 0, 0, 0, 0);
    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      int ri;
      ri = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 127)) - 64
                                       : int'($urandom_range(0, 39)) - 8;
      cycle(0, $urandom_range(0, 9) != 0, 2'($urandom_range(0, 3)),
            $urandom_range(0, 2) == 0, ri, $urandom_range(0, 5) == 0,
            $urandom_range(0, 3) != 0, $urandom_range(0, 199) == 0);
    end
    // reach HOLD with a stalled fragment, then reset mid-operation
    repeat (70) cycle(0, 1, 2'($urandom_range(0, 3)), 0, 0, 0, 0, 0);
    repeat (2) cycle(0, 1, 2'($urandom_range(0, 3)), 1, 5, 0, 0, 0);
    cycle(1, 1, 2'($urandom_range(0, 3)), 1, 5, 0, 0, 0);
    // refill after reset: swap at the 32nd word with bank_cnt back to 1
    repeat (34) cycle(0, 1, 2'($urandom_range(0, 3)), 0, 0, 0, 1, 0);
    cycle(0, 1, 2'($urandom_range(0, 3)), 1, 2, 0, 1, 0);
    repeat (3) cycle(0, 1, 2'($urandom_range(0, 3)), 0, 0, 0, 1, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
